// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: owns the fetch PC, picks the next PC and parks fetch on illegal addresses until CP0 takes the exception.
module fetch_pc_ctrl #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int          IM_WORDS   = 4096,
  parameter int          IDX_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             exc_req_i,
  input  logic             eret_i,
  input  logic [31:0]      epc_i,
  output logic [31:0]      pc_o,
  output logic [IDX_W-1:0] im_index_o,
  output logic             fetch_valid_o,
  output logic             fetch_exc_o,
  output logic [4:0]       fetch_exccode_o,
  output logic             flush_o
);
  typedef enum logic {RUN, WAIT_EXC} state_t;
  // 33-bit end address so a ROM ending at 2^32 cannot wrap the bound
  localparam logic [32:0] IM_END = 33'(IM_BASE) + 33'(4 * IM_WORDS);
  state_t      state;
  logic        pend_v;
  logic [31:0] pend_pc;
  logic        addr_err;
  always_comb begin
    addr_err        = (pc_o[1:0] != 2'b00) || (pc_o < IM_BASE) || ({1'b0, pc_o} >= IM_END);
    im_index_o      = IDX_W'((pc_o - IM_BASE) >> 2);
    fetch_valid_o   = (state == RUN) && !addr_err;
    fetch_exc_o     = (state == RUN) && addr_err;
    fetch_exccode_o = fetch_exc_o ? 5'd4 : 5'd0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_o    <= PC_RESET;
      state   <= RUN;
      pend_v  <= 1'b0;
      pend_pc <= 32'h0;
      flush_o <= 1'b0;
    end else begin
      flush_o <= exc_req_i || eret_i;
      if (exc_req_i) begin
        pc_o   <= HANDLER_PC;
        pend_v <= 1'b0;
        state  <= RUN;
      end else if (eret_i) begin
        pc_o   <= epc_i;
        pend_v <= 1'b0;
        state  <= RUN;
      end else if (state == RUN) begin
        if (stall_i) begin
          if (redirect_valid_i) begin
            pend_v  <= 1'b1;
            pend_pc <= redirect_pc_i;
          end
        end else if (addr_err) begin
          state  <= WAIT_EXC;
          pend_v <= 1'b0;
        end else begin
          pc_o   <= redirect_valid_i ? redirect_pc_i : pend_v ? pend_pc : pc_o + 32'd4;
          pend_v <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed scenarios plus random traffic against a behavioural fetch model.
module tb_fetch_pc_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redir, exc, eret;
  logic [31:0] redir_pc, epc;
  logic [31:0] pc;
  logic [11:0] idx;
  logic        valid, fexc, flush;
  logic [4:0]  code;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_pc, m_pend_pc;
  bit          m_wait, m_pend_v, m_flush;

  fetch_pc_ctrl dut (
    .clk(clk), .reset(reset), .stall_i(stall), .redirect_valid_i(redir),
    .redirect_pc_i(redir_pc), .exc_req_i(exc), .eret_i(eret), .epc_i(epc),
    .pc_o(pc), .im_index_o(idx), .fetch_valid_o(valid), .fetch_exc_o(fexc),
    .fetch_exccode_o(code), .flush_o(flush)
  );

  always #5 clk = ~clk;

  function automatic bit legal(logic [31:0] p);
    return (p % 4 == 0) && (p >= 32'h3000) && (p < 32'h3000 + 4 * 4096);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 32'h3000; m_wait = 0; m_pend_v = 0; m_pend_pc = 0; m_flush = 0;
  endfunction

  function automatic void model_edge();
    bit bad;
    bad = !legal(m_pc);
    m_flush = exc || eret;
    if (exc) begin
      m_pc = 32'h4180; m_pend_v = 0; m_wait = 0;
    end else if (eret) begin
      m_pc = epc; m_pend_v = 0; m_wait = 0;
    end else if (m_wait) begin
    end else if (stall) begin
      if (redir) begin m_pend_v = 1; m_pend_pc = redir_pc; end
    end else if (bad) begin
      m_wait = 1; m_pend_v = 0;
    end else if (redir) begin
      m_pc = redir_pc; m_pend_v = 0;
    end else if (m_pend_v) begin
      m_pc = m_pend_pc; m_pend_v = 0;
    end else m_pc = m_pc + 4;
  endfunction

  task automatic check_all();
    bit ok;
    logic [31:0] off;
    ok = legal(m_pc);
    off = (m_pc - 32'h3000) / 4;
    check("pc", pc, m_pc);
    check("index", 32'(idx), off % 4096);
    check("valid", 32'(valid), 32'(!m_wait && ok));
    check("exc", 32'(fexc), 32'(!m_wait && !ok));
    check("code", 32'(code), (!m_wait && !ok) ? 32'd4 : 32'd0);
    check("flush", 32'(flush), 32'(m_flush));
  endtask

  task automatic idle();
    stall = 0; redir = 0; exc = 0; eret = 0; redir_pc = 0; epc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rand_target();
    int r;
    r = $urandom_range(0, 9);
    return r < 7 ? 32'h3000 + 4 * $urandom_range(0, 4095) :
           r == 7 ? 32'h6FF0 + 4 * $urandom_range(0, 3) :
           r == 8 ? 32'h3000 + 4 * $urandom_range(0, 4095) + $urandom_range(1, 3) :
           $urandom;
  endfunction

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    check_all();
    check("t1_pc0", pc, 32'h3000);
    step(); check("t1_idx1", 32'(idx), 32'd1);
    step(); check("t1_pc2", pc, 32'h3008);
    stall = 1; step();
    redir = 1; redir_pc = 32'h3100; step(); check("t2_hold", pc, 32'h3008);
    redir = 0; step();
    stall = 0; step(); check("t2_pend", pc, 32'h3100);
    step(); check("t2_next", pc, 32'h3104);
    stall = 1; redir = 1; redir_pc = 32'h3200; exc = 1; step();
    check("t3_handler", pc, 32'h4180); check("t3_flush", 32'(flush), 32'd1);
    idle(); step(); check("t3_nopend", pc, 32'h4184); check("t3_flush0", 32'(flush), 32'd0);
    redir = 1; redir_pc = 32'h3002; step();
    check("t4_exc", 32'(fexc), 32'd1); check("t4_code", 32'(code), 32'd4);
    idle(); step(); check("t4_wait_pc", pc, 32'h3002); check("t4_wait_exc", 32'(fexc), 32'd0);
    stall = 1; redir = 1; redir_pc = 32'h3300; step(); check("t4_ignore", pc, 32'h3002);
    idle(); exc = 1; step(); check("t4_handler", pc, 32'h4180);
    step(); check("b2b_flush", 32'(flush), 32'd1);
    idle(); eret = 1; epc = 32'h3010; redir = 1; redir_pc = 32'h3400; step();
    check("t5_eret", pc, 32'h3010); check("t5_flush", 32'(flush), 32'd1);
    idle(); redir = 1; redir_pc = 32'h6FFC; step(); check("t6_valid", 32'(valid), 32'd1);
    idle(); step(); check("t6_end", pc, 32'h7000); check("t6_exc", 32'(fexc), 32'd1);
    step(); check("t6_wait", 32'(valid), 32'd0);
    #2 reset = 1;
    #1 check("async_rst", pc, 32'h3000);
    #1 reset = 0;
    model_reset();
    check_all();
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      redir = ($urandom_range(0, 2) == 0);
      redir_pc = rand_target();
      exc = ($urandom_range(0, 39) == 0);
      eret = ($urandom_range(0, 39) == 0);
      epc = rand_target();
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
